// File: rtl/jtag_tap_controller_if.sv
// jtag_tap_controller_if
// Groups the TAP steering input and the six capture/shift/update strobes.
//   tms              : test mode select, driven by the JTAG pin side
//   cdr1, sdr1, udr1 : Capture-DR / Shift-DR / Update-DR strobes
//   cir1, sir1, uir1 : Capture-IR / Shift-IR / Update-IR strobes
// The master modport is the pin/host side; the slave modport is the TAP.
interface jtag_tap_controller_if;
  logic tms;
  logic cdr1;
  logic sdr1;
  logic udr1;
  logic cir1;
  logic sir1;
  logic uir1;

  modport master (
    output tms,
    input  cdr1, sdr1, udr1, cir1, sir1, uir1
  );

  modport slave (
    input  tms,
    output cdr1, sdr1, udr1, cir1, sir1, uir1
  );
endinterface

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller
// IEEE 1149.1 TAP state machine. It is steered by tms on each rising tck edge
// and produces one-hot strobes for the DR and IR capture/shift/update phases.
//   tck  : test clock, all state changes on its rising edge
//   trst : synchronous active-high reset to Test-Logic-Reset
//   tap  : slave modport (tms in, six strobes out)
module jtag_tap_controller (
  input  logic                  tck,
  input  logic                  trst,
  jtag_tap_controller_if.slave  tap
);

  typedef enum logic [3:0] {
    TLR   = 4'd0,
    RTI   = 4'd1,
    SELDR = 4'd2,
    CAPDR = 4'd3,
    SHDR  = 4'd4,
    EX1DR = 4'd5,
    PAUDR = 4'd6,
    EX2DR = 4'd7,
    UPDDR = 4'd8,
    SELIR = 4'd9,
    CAPIR = 4'd10,
    SHIR  = 4'd11,
    EX1IR = 4'd12,
    PAUIR = 4'd13,
    EX2IR = 4'd14,
    UPDIR = 4'd15
  } tap_state_e;

  tap_state_e state_q;
  tap_state_e state_d;
  logic [5:0] strobe_q;
  logic [5:0] strobe_d;

  // Strobe decode, packed as {cdr1, sdr1, udr1, cir1, sir1, uir1}.
  function automatic logic [5:0] decode_strobes(input tap_state_e st);
    logic [5:0] s;
    case (st)
      CAPDR:   s = 6'b100000;
      SHDR:    s = 6'b010000;
      UPDDR:   s = 6'b001000;
      CAPIR:   s = 6'b000100;
      SHIR:    s = 6'b000010;
      UPDIR:   s = 6'b000001;
      default: s = 6'b000000;
    endcase
    return s;
  endfunction

  // Next-state logic: the standard TAP transition table, with trst overriding tms.
  always_comb begin
    state_d = TLR;
    if (trst) begin
      state_d = TLR;
    end else begin
      case (state_q)
        TLR:     state_d = tap.tms ? TLR   : RTI;
        RTI:     state_d = tap.tms ? SELDR : RTI;
        SELDR:   state_d = tap.tms ? SELIR : CAPDR;
        CAPDR:   state_d = tap.tms ? EX1DR : SHDR;
        SHDR:    state_d = tap.tms ? EX1DR : SHDR;
        EX1DR:   state_d = tap.tms ? UPDDR : PAUDR;
        PAUDR:   state_d = tap.tms ? EX2DR : PAUDR;
        EX2DR:   state_d = tap.tms ? UPDDR : SHDR;
        UPDDR:   state_d = tap.tms ? SELDR : RTI;
        SELIR:   state_d = tap.tms ? TLR   : CAPIR;
        CAPIR:   state_d = tap.tms ? EX1IR : SHIR;
        SHIR:    state_d = tap.tms ? EX1IR : SHIR;
        EX1IR:   state_d = tap.tms ? UPDIR : PAUIR;
        PAUIR:   state_d = tap.tms ? EX2IR : PAUIR;
        EX2IR:   state_d = tap.tms ? UPDIR : SHIR;
        UPDIR:   state_d = tap.tms ? SELDR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // Strobes are decoded from the next state and registered alongside it,
  // so they are exact Moore decodes of state_q with no added latency.
  always_comb begin
    strobe_d = decode_strobes(state_d);
  end

  // State and strobe registers with synchronous reset to Test-Logic-Reset.
  always_ff @(posedge tck) begin
    if (trst) begin
      state_q  <= TLR;
      strobe_q <= 6'b000000;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_d;
    end
  end

  assign tap.cdr1 = strobe_q[5];
  assign tap.sdr1 = strobe_q[4];
  assign tap.udr1 = strobe_q[3];
  assign tap.cir1 = strobe_q[2];
  assign tap.sir1 = strobe_q[1];
  assign tap.uir1 = strobe_q[0];

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb_jtag_tap_controller
// Directed TMS/TRST sequences with hand-computed strobe vectors, packed as
// {cdr1, sdr1, udr1, cir1, sir1, uir1}, checked after every rising tck edge.
module tb_jtag_tap_controller;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] CDR  = 6'b100000;
  localparam logic [5:0] SDR  = 6'b010000;
  localparam logic [5:0] UDR  = 6'b001000;
  localparam logic [5:0] CIR  = 6'b000100;
  localparam logic [5:0] SIR  = 6'b000010;
  localparam logic [5:0] UIR  = 6'b000001;

  logic tck;
  logic trst;
  int   n_cmp;
  int   n_bad;

  jtag_tap_controller_if tap_if ();

  jtag_tap_controller dut (
    .tck  (tck),
    .trst (trst),
    .tap  (tap_if.slave)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, then sample just after the edge.
  task automatic step(input logic tms_v, input logic trst_v, input logic [5:0] exp, input string tag);
    @(negedge tck);
    tap_if.tms = tms_v;
    trst       = trst_v;
    @(posedge tck);
    #1;
    check_val(tag, {tap_if.cdr1, tap_if.sdr1, tap_if.udr1,
                    tap_if.cir1, tap_if.sir1, tap_if.uir1}, exp);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    trst       = 1'b1;
    tap_if.tms = 1'b0;

    // Reset held with tms toggling, then released with tms=1 (stay in TLR).
    step(1'b0, 1'b1, NONE, "rst_tms0");
    step(1'b1, 1'b1, NONE, "rst_tms1");
    step(1'b1, 1'b0, NONE, "tlr_hold1");
    step(1'b1, 1'b0, NONE, "tlr_hold2");
    step(1'b1, 1'b0, NONE, "tlr_hold3");

    // DR scan: 0,1,0,0,0,0,1,1,0
    step(1'b0, 1'b0, NONE, "dr_rti");
    step(1'b1, 1'b0, NONE, "dr_seldr");
    step(1'b0, 1'b0, CDR,  "dr_capdr");
    step(1'b0, 1'b0, SDR,  "dr_shdr1");
    step(1'b0, 1'b0, SDR,  "dr_shdr2");
    step(1'b0, 1'b0, SDR,  "dr_shdr3");
    step(1'b1, 1'b0, NONE, "dr_ex1dr");
    step(1'b1, 1'b0, UDR,  "dr_upddr");
    step(1'b0, 1'b0, NONE, "dr_rti_end");

    // IR scan with pause: 1,1,0,0,1,0,0,1,0,1,1
    step(1'b1, 1'b0, NONE, "ir_seldr");
    step(1'b1, 1'b0, NONE, "ir_selir");
    step(1'b0, 1'b0, CIR,  "ir_capir");
    step(1'b0, 1'b0, SIR,  "ir_shir1");
    step(1'b1, 1'b0, NONE, "ir_ex1ir");
    step(1'b0, 1'b0, NONE, "ir_pauir1");
    step(1'b0, 1'b0, NONE, "ir_pauir2");
    step(1'b1, 1'b0, NONE, "ir_ex2ir");
    step(1'b0, 1'b0, SIR,  "ir_shir2");
    step(1'b1, 1'b0, NONE, "ir_ex1ir2");
    step(1'b1, 1'b0, UIR,  "ir_updir");
    step(1'b0, 1'b0, NONE, "updir_rti");

    // Escape from ShDR with five tms=1 edges.
    step(1'b1, 1'b0, NONE, "esc_seldr");
    step(1'b0, 1'b0, CDR,  "esc_capdr");
    step(1'b0, 1'b0, SDR,  "esc_shdr");
    step(1'b1, 1'b0, NONE, "esc_ex1dr");
    step(1'b1, 1'b0, UDR,  "esc_upddr");
    step(1'b1, 1'b0, NONE, "esc_seldr2");
    step(1'b1, 1'b0, NONE, "esc_selir");
    step(1'b1, 1'b0, NONE, "esc_tlr");
    // Prove TLR: tms=1 holds, then 0,1,0 must land in CapDR.
    step(1'b1, 1'b0, NONE, "esc_tlr_hold");
    step(1'b0, 1'b0, NONE, "esc_rti");
    step(1'b1, 1'b0, NONE, "esc_seldr3");
    step(1'b0, 1'b0, CDR,  "esc_capdr2");

    // From SelIR a single tms=1 edge reaches TLR.
    step(1'b1, 1'b0, NONE, "sel_ex1dr");
    step(1'b1, 1'b0, UDR,  "sel_upddr");
    step(1'b1, 1'b0, NONE, "sel_seldr");
    step(1'b1, 1'b0, NONE, "sel_selir");
    step(1'b1, 1'b0, NONE, "sel_tlr");
    step(1'b1, 1'b0, NONE, "sel_tlr_hold");
    step(1'b0, 1'b0, NONE, "sel_rti");

    // Reset mid-shift in ShIR.
    step(1'b1, 1'b0, NONE, "mid_seldr");
    step(1'b1, 1'b0, NONE, "mid_selir");
    step(1'b0, 1'b0, CIR,  "mid_capir");
    step(1'b0, 1'b0, SIR,  "mid_shir");
    step(1'b0, 1'b1, NONE, "mid_trst");
    step(1'b0, 1'b0, NONE, "mid_rti");
    step(1'b1, 1'b0, NONE, "mid_seldr2");
    step(1'b0, 1'b0, CDR,  "mid_capdr");

    // Back-to-back DR updates, plus the pause/exit2 path back into ShDR.
    step(1'b1, 1'b0, NONE, "b2b_ex1dr");
    step(1'b1, 1'b0, UDR,  "b2b_upddr1");
    step(1'b1, 1'b0, NONE, "b2b_seldr");
    step(1'b0, 1'b0, CDR,  "b2b_capdr");
    step(1'b0, 1'b0, SDR,  "b2b_shdr");
    step(1'b1, 1'b0, NONE, "b2b_ex1dr2");
    step(1'b0, 1'b0, NONE, "b2b_paudr");
    step(1'b1, 1'b0, NONE, "b2b_ex2dr");
    step(1'b0, 1'b0, SDR,  "b2b_shdr2");
    step(1'b1, 1'b0, NONE, "b2b_ex1dr3");
    step(1'b1, 1'b0, UDR,  "b2b_upddr2");
    step(1'b0, 1'b0, NONE, "b2b_rti");

    // IR pause then Exit2-IR straight to Update-IR.
    step(1'b1, 1'b0, NONE, "irp_seldr");
    step(1'b1, 1'b0, NONE, "irp_selir");
    step(1'b0, 1'b0, CIR,  "irp_capir");
    step(1'b1, 1'b0, NONE, "irp_ex1ir");
    step(1'b0, 1'b0, NONE, "irp_pauir");
    step(1'b1, 1'b0, NONE, "irp_ex2ir");
    step(1'b1, 1'b0, UIR,  "irp_updir");
    step(1'b1, 1'b0, NONE, "irp_seldr2");
    step(1'b0, 1'b0, CDR,  "irp_capdr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1 Test Access Port (TAP) controller: a 16-state Moore FSM clocked by the test clock and steered by TMS. It decodes the current state into six one-hot strobes that tell the DR and IR shift-register chains when to capture, shift and update. It sits between the JTAG pins and the boundary-scan/instruction register datapath.

## Interface
- Parameters: none.
- tck  input  1  test clock; all state changes on its rising edge.
- trst  input  1  reset, synchronous, active-high; sampled on the rising edge of tck.
- tms  input  1  test mode select; steers FSM transitions, sampled on the rising edge of tck.
- cdr1  output  1  high while the state is Capture-DR.
- sdr1  output  1  high while the state is Shift-DR.
- udr1  output  1  high while the state is Update-DR.
- cir1  output  1  high while the state is Capture-IR.
- sir1  output  1  high while the state is Shift-IR.
- uir1  output  1  high while the state is Update-IR.

## Operation
- State register, 4 bits, any binary encoding; the 16 states are TLR (Test-Logic-Reset), RTI (Run-Test/Idle), SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
- Transitions, written as next state for tms=0 / tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauDR / UpdDR
  - PauDR: PauDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - CapIR: ShIR / Ex1IR
  - ShIR: ShIR / Ex1IR
  - Ex1IR: PauIR / UpdIR
  - PauIR: PauIR / Ex2IR
  - Ex2IR: ShIR / UpdIR
  - UpdIR: RTI / SelDR
- Outputs are pure decodes of the registered state (Moore). Exactly one output is high in the six named states; all six are low in the other ten states.
- Any unused or illegal encoding must go to TLR on the next edge.
- From any state, five consecutive edges with tms=1 reach TLR, independent of trst.

## Timing
- Reset: trst=1 at a rising tck edge forces the state to TLR, overriding tms. All outputs are 0 in TLR.
- If trst is held high, the FSM stays in TLR regardless of tms. After trst falls, the first edge with tms=0 moves the FSM to RTI.
- If trst is asserted mid-operation (for example in ShDR), the FSM goes to TLR on that edge, and the active strobe drops in the same cycle the state changes.
- Latency: an output asserts after the rising edge that enters its state and deasserts after the edge that leaves it. There is no extra pipeline stage.
- Each strobe stays high for as many tck cycles as the FSM remains in the state. Only sdr1 and sir1 can be high for more than one cycle (tms=0 loops). cdr1, udr1, cir1 and uir1 are always single-cycle pulses.
- tms must be stable around the rising tck edge. No glitch filtering is done.

## Test plan
- Reset: trst=1 for 2 edges with tms toggling -> state TLR, all six outputs 0. Release trst and drive tms=1 for 3 edges -> FSM stays in TLR.
- DR scan: from TLR, tms sequence 0,1,0,0,0,0,1,1,0 -> RTI, SelDR, CapDR (cdr1=1 for 1 cycle), ShDR for 3 cycles (sdr1=1), Ex1DR, UpdDR (udr1=1 for 1 cycle), RTI. No other output goes high.
- IR scan with pause: from RTI, tms 1,1,0,0,1,0,0,1,0,1,1 -> SelDR, SelIR, CapIR (cir1=1), ShIR (sir1=1), Ex1IR, PauIR for 2 cycles, Ex2IR, ShIR (sir1=1 again), Ex1IR, UpdIR (uir1=1).
- Escape: from ShDR, drive tms=1 for 5 edges -> Ex1DR, UpdDR, SelDR, SelIR, TLR, with all outputs 0 at the end. From SelIR, a single tms=1 edge -> TLR.
- Reset mid-shift: enter ShIR (sir1=1), then assert trst for one edge with tms=0 -> TLR, sir1=0 in the next cycle.
- Back-to-back updates: from UpdDR, tms 1,0,0 -> SelDR, CapDR, ShDR. From UpdIR, tms 0 -> RTI. Check that the outputs are one-hot at every edge.
